// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_sched_pkg;

    localparam int ALU_OPW = 3;
    localparam int ALU_RW  = ALU_OPW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_EQ   = 2'b10;
    localparam logic [1:0] OP_HALF = 2'b11;

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Combinational two-way round-robin arbiter; last_grant is the index served most recently.
module alu_sched_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the requester that was not served last wins.
        if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two clients: accept, issue, capture, respond.
// Define ALU_SCHED_CNT_EN to add per-requester saturating completion counters.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int OPW   = ALU_OPW,
    parameter int RW    = ALU_RW,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op,
    input  logic [2*OPW-1:0] req_a,
    input  logic [2*OPW-1:0] req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [RW-1:0]    rsp_q,
    output logic [1:0]       alu_sel,
    output logic [OPW-1:0]   alu_a,
    output logic [OPW-1:0]   alu_b,
    input  logic [RW-1:0]    alu_q,
`ifdef ALU_SCHED_CNT_EN
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic             g_q, g_d;
    logic             last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [OPW-1:0]   a_q, a_d, b_q, b_d;
    logic [RW-1:0]    res_q, res_d;
    logic [1:0]       gnt;
    logic             gidx;
    logic [1:0]       win_op;
    logic             rsp_hs;

    alu_sched_rr_arb u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (gnt)
    );

    assign gidx   = gnt[1];
    assign win_op = gidx ? req_op[3:2] : req_op[1:0];
    assign rsp_hs = (state_q == RESPOND) && rsp_ready[g_q];

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d = ISSUE;
                g_d     = gidx;
                sel_d   = win_op;
                a_d     = gidx ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
                b_d     = gidx ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
                // Halve is unary; present a clean zero on the unused operand.
                if (win_op == OP_HALF) b_d = '0;
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                res_d   = alu_q;
                state_d = RESPOND;
            end
            RESPOND: if (rsp_hs) begin
                last_d  = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
    assign rsp_valid = (state_q == RESPOND) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_q     = res_q;
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (rsp_hs) begin
            if (!g_q && cnt0_q != {CNT_W{1'b1}}) cnt0_q <= cnt0_q + 1'b1;
            if (g_q && cnt1_q != {CNT_W{1'b1}})  cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [3:0] req_op = '0;
    logic [5:0] req_a = '0;
    logic [5:0] req_b = '0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = '0;
    logic [3:0] rsp_q;
    logic [1:0] alu_sel;
    logic [2:0] alu_a, alu_b;
    logic [3:0] alu_q;
    logic       busy;
`ifdef ALU_SCHED_CNT_EN
    logic [7:0] done_cnt0, done_cnt1;
`endif

    int tests = 0;
    int fails = 0;
    int lg = 1;

    always #5 clk = ~clk;

    alu_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q),
`ifdef ALU_SCHED_CNT_EN
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1),
`endif
        .busy(busy)
    );

    // Stand-in for the external ALU.
    always_comb begin
        case (alu_sel)
            2'b00:   alu_q = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_q = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   alu_q = {1'b0, alu_a ~^ alu_b};
            default: alu_q = {2'b00, alu_a[2:1]};
        endcase
    end

    // Expected response from the requester's view of the operation.
    function automatic logic [3:0] ref_q(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = 7 & ~(a ^ b);
            default: r = a / 2;
        endcase
        return 4'(r & 15);
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        req_op[2*i +: 2] = op;
        req_a[3*i +: 3]  = a;
        req_b[3*i +: 3]  = b;
        req_valid[i]     = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
        tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); end
        tests++; if (rsp_q !== 4'h0) begin fails++; $display("FAIL reset_rsp_q: got %h exp 0", rsp_q); end
        tests++; if ({alu_sel, alu_a, alu_b} !== 8'h00) begin fails++; $display("FAIL reset_alu: got %h exp 00", {alu_sel, alu_a, alu_b}); end
        rst = 1'b0; lg = 1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        set_req(0, 2'b00, 3'b011, 3'b001); #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL add_ready: got %b exp 01", req_ready); end
        @(negedge clk); req_valid = '0;
        tests++; if ({busy, req_ready} !== 3'b100) begin fails++; $display("FAIL add_issue_busy: got %b exp 100", {busy, req_ready}); end
        tests++; if ({alu_sel, alu_a, alu_b} !== {2'b00, 3'b011, 3'b001}) begin fails++; $display("FAIL add_alu: got %h exp %h", {alu_sel, alu_a, alu_b}, {2'b00, 3'b011, 3'b001}); end
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL add_early_rsp: got %b exp 00", rsp_valid); end
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b01 || rsp_q !== 4'b0100) begin fails++; $display("FAIL add_rsp: got %b/%h exp 01/4", rsp_valid, rsp_q); end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0; lg = 0;
        tests++; if ({busy, rsp_valid} !== 3'b000) begin fails++; $display("FAIL add_done: got %b exp 000", {busy, rsp_valid}); end
    endtask

    task automatic test_overflow_add();
        set_req(1, 2'b00, 3'b100, 3'b111); #1;
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL ovf_ready: got %b exp 10", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b10 || rsp_q !== 4'b1011) begin fails++; $display("FAIL ovf_rsp: got %b/%h exp 10/b", rsp_valid, rsp_q); end
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = '0; lg = 1;
    endtask

    task automatic test_tie();
        set_req(0, 2'b01, 3'd7, 3'd7);
        set_req(1, 2'b00, 3'd3, 3'd1); #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL tie_first: got %b exp 01", req_ready); end
        @(negedge clk); req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b01 || rsp_q !== 4'b0000) begin fails++; $display("FAIL tie_rsp0: got %b/%h exp 01/0", rsp_valid, rsp_q); end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0;
        set_req(0, 2'b01, 3'd7, 3'd7); #1;
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL tie_second: got %b exp 10", req_ready); end
        @(negedge clk); req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b10 || rsp_q !== 4'b0100) begin fails++; $display("FAIL tie_rsp1: got %b/%h exp 10/4", rsp_valid, rsp_q); end
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = '0; #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL tie_third: got %b exp 01", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b01 || rsp_q !== 4'b0000) begin fails++; $display("FAIL tie_rsp2: got %b/%h exp 01/0", rsp_valid, rsp_q); end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0; lg = 0;
    endtask

    task automatic test_halve();
        set_req(0, 2'b11, 3'b101, 3'b110);
        @(negedge clk); req_valid = '0;
        tests++; if ({alu_sel, alu_a, alu_b} !== {2'b11, 3'b101, 3'b000}) begin fails++; $display("FAIL half_alu: got %h exp %h", {alu_sel, alu_a, alu_b}, {2'b11, 3'b101, 3'b000}); end
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_q !== ref_q(3, 5, 6)) begin fails++; $display("FAIL half_rsp: got %h exp %h", rsp_q, ref_q(3, 5, 6)); end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0; lg = 0;
    endtask

    task automatic test_backpressure();
        set_req(0, 2'b00, 3'd2, 3'd2);
        set_req(1, 2'b01, 3'd5, 3'd1); #1;
        tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_first: got %b exp 10", req_ready); end
        @(negedge clk); req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rsp_valid !== 2'b10 || rsp_q !== 4'h4 || busy !== 1'b1 || req_ready !== 2'b00) begin
                fails++; $display("FAIL bp_hold%0d: got %b/%h/%b/%b exp 10/4/1/00", i, rsp_valid, rsp_q, busy, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = '0; #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_next: got %b exp 01", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (rsp_valid !== 2'b01 || rsp_q !== 4'h4) begin fails++; $display("FAIL bp_rsp0: got %b/%h exp 01/4", rsp_valid, rsp_q); end
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0; lg = 0;
    endtask

    task automatic test_reset_mid();
        set_req(0, 2'b00, 3'd1, 3'd1);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        rst = 1'b1; #1;
        tests++; if ({busy, rsp_valid, req_ready} !== 5'b0) begin fails++; $display("FAIL rmid_ctrl: got %b exp 00000", {busy, rsp_valid, req_ready}); end
        tests++; if ({rsp_q, alu_sel, alu_a, alu_b} !== 12'h000) begin fails++; $display("FAIL rmid_data: got %h exp 000", {rsp_q, alu_sel, alu_a, alu_b}); end
        @(negedge clk); rst = 1'b0; lg = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL rmid_replay%0d: got %b/%b exp 00/0", i, rsp_valid, busy); end
        end
        set_req(0, 2'b00, 3'd1, 3'd1);
        set_req(1, 2'b00, 3'd1, 3'd1); #1;
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rmid_tie: got %b exp 01", req_ready); end
        #1 req_valid = '0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_busy: got %b exp 0", busy); end
    endtask

    task automatic test_random();
        int pv[2], pop[2], pa[2], pb[2];
        int g, d, eb;
        logic [1:0] eg;
        pv[0] = 0; pv[1] = 0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (pv[i] == 0 && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1; pop[i] = $urandom_range(0, 3);
                    pa[i] = $urandom_range(0, 7); pb[i] = $urandom_range(0, 7);
                end
            end
            if (pv[0] == 0 && pv[1] == 0) begin
                pv[0] = 1; pop[0] = $urandom_range(0, 3);
                pa[0] = $urandom_range(0, 7); pb[0] = $urandom_range(0, 7);
            end
            for (int i = 0; i < 2; i++)
                if (pv[i] != 0) set_req(i, 2'(pop[i]), 3'(pa[i]), 3'(pb[i]));
            #1;
            g  = (pv[0] != 0 && pv[1] != 0) ? (lg == 1 ? 0 : 1) : (pv[0] != 0 ? 0 : 1);
            eg = (g == 0) ? 2'b01 : 2'b10;
            tests++; if (req_ready !== eg) begin fails++; $display("FAIL rnd%0d_grant: got %b exp %b", n, req_ready, eg); end
            @(negedge clk);
            pv[g] = 0; req_valid[g] = 1'b0;
            eb = (pop[g] == 3) ? 0 : pb[g];
            tests++;
            if ({alu_sel, alu_a, alu_b} !== {2'(pop[g]), 3'(pa[g]), 3'(eb)}) begin
                fails++; $display("FAIL rnd%0d_alu: got %h exp %h", n, {alu_sel, alu_a, alu_b}, {2'(pop[g]), 3'(pa[g]), 3'(eb)});
            end
            @(negedge clk);
            @(negedge clk);
            d = $urandom_range(0, 2);
            rsp_ready[1-g] = 1'($urandom_range(0, 1));
            for (int k = 0; k < d; k++) @(negedge clk);
            tests++;
            if (rsp_valid !== eg || rsp_q !== ref_q(pop[g], pa[g], pb[g])) begin
                fails++; $display("FAIL rnd%0d_rsp: got %b/%h exp %b/%h", n, rsp_valid, rsp_q, eg, ref_q(pop[g], pa[g], pb[g]));
            end
            rsp_ready[g] = 1'b1;
            @(negedge clk);
            rsp_ready = '0; lg = g;
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd%0d_idle: got %b exp 0", n, busy); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow_add();
        test_tie();
        test_halve();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
